// File: rtl/scr1_lsu_pkg.sv
// Shared LSU types: commands, exception codes, DMEM encodings, outstanding-entry struct.
// No logic; consumed by the LSU top, its tracker FIFO and the LSU interface.
// SCR1_LSU_BYTE_LANE_EN adds the low address bits to the outstanding entry.
package scr1_lsu_pkg;

    localparam int unsigned SCR1_XLEN      = 32;
    // Counter width covers 0..8, the largest legal outstanding depth.
    localparam int unsigned SCR1_LSU_CNT_W = 4;

    typedef enum logic [3:0] {
        SCR1_LSU_CMD_NONE = 4'd0,
        SCR1_LSU_CMD_LB   = 4'd1,
        SCR1_LSU_CMD_LH   = 4'd2,
        SCR1_LSU_CMD_LW   = 4'd3,
        SCR1_LSU_CMD_LBU  = 4'd4,
        SCR1_LSU_CMD_LHU  = 4'd5,
        SCR1_LSU_CMD_SB   = 4'd6,
        SCR1_LSU_CMD_SH   = 4'd7,
        SCR1_LSU_CMD_SW   = 4'd8
    } type_scr1_lsu_cmd_sel_e;

    typedef enum logic [3:0] {
        SCR1_EXC_CODE_INSTR_MISALIGN   = 4'd0,
        SCR1_EXC_CODE_LD_ADDR_MISALIGN = 4'd4,
        SCR1_EXC_CODE_LD_ACCESS_FAULT  = 4'd5,
        SCR1_EXC_CODE_ST_ADDR_MISALIGN = 4'd6,
        SCR1_EXC_CODE_ST_ACCESS_FAULT  = 4'd7
    } type_scr1_exc_code_e;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;

    typedef struct packed {
        type_scr1_lsu_cmd_sel_e cmd;
`ifdef SCR1_LSU_BYTE_LANE_EN
        logic [1:0]             addr;
`endif
        logic                   killed;
    } type_scr1_lsu_outst_s;

    // All-zero entry: cmd NONE (encoded 0), not killed.
    localparam type_scr1_lsu_outst_s SCR1_LSU_OUTST_RESET = type_scr1_lsu_outst_s'('0);

    // Pointer width for a tracker of the given depth (depth 1 still needs one bit).
    function automatic int unsigned scr1_lsu_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/scr1_pipe_lsu_mo_if.sv
// LSU handshake bundle: EXU request/completion plus DMEM request/response channels.
// master = LSU side (drives lsu2exu_*/lsu2dmem_*), slave = EXU + DMEM side.
// Pure wiring, no latency; flow control is req/req_ack on both channels.
interface scr1_pipe_lsu_mo_if;
    import scr1_lsu_pkg::*;

    logic                   exu2lsu_req_i;
    type_scr1_lsu_cmd_sel_e exu2lsu_cmd_i;
    logic [SCR1_XLEN-1:0]   exu2lsu_addr_i;
    logic [SCR1_XLEN-1:0]   exu2lsu_sdata_i;
    logic                   exu2lsu_flush_i;

    logic                   lsu2exu_req_ack_o;
    logic                   lsu2exu_rdy_o;
    logic [SCR1_XLEN-1:0]   lsu2exu_ldata_o;
    logic                   lsu2exu_exc_o;
    type_scr1_exc_code_e    lsu2exu_exc_code_o;
    logic                   lsu2exu_empty_o;

    logic                   lsu2dmem_req_o;
    type_scr1_mem_cmd_e     lsu2dmem_cmd_o;
    type_scr1_mem_width_e   lsu2dmem_width_o;
    logic [SCR1_XLEN-1:0]   lsu2dmem_addr_o;
    logic [SCR1_XLEN-1:0]   lsu2dmem_wdata_o;

    logic                   dmem2lsu_req_ack_i;
    logic [SCR1_XLEN-1:0]   dmem2lsu_rdata_i;
    type_scr1_mem_resp_e    dmem2lsu_resp_i;

    modport master (
        input  exu2lsu_req_i, exu2lsu_cmd_i, exu2lsu_addr_i, exu2lsu_sdata_i, exu2lsu_flush_i,
        output lsu2exu_req_ack_o, lsu2exu_rdy_o, lsu2exu_ldata_o, lsu2exu_exc_o,
               lsu2exu_exc_code_o, lsu2exu_empty_o,
        output lsu2dmem_req_o, lsu2dmem_cmd_o, lsu2dmem_width_o, lsu2dmem_addr_o, lsu2dmem_wdata_o,
        input  dmem2lsu_req_ack_i, dmem2lsu_rdata_i, dmem2lsu_resp_i
    );

    modport slave (
        output exu2lsu_req_i, exu2lsu_cmd_i, exu2lsu_addr_i, exu2lsu_sdata_i, exu2lsu_flush_i,
        input  lsu2exu_req_ack_o, lsu2exu_rdy_o, lsu2exu_ldata_o, lsu2exu_exc_o,
               lsu2exu_exc_code_o, lsu2exu_empty_o,
        input  lsu2dmem_req_o, lsu2dmem_cmd_o, lsu2dmem_width_o, lsu2dmem_addr_o, lsu2dmem_wdata_o,
        output dmem2lsu_req_ack_i, dmem2lsu_rdata_i, dmem2lsu_resp_i
    );

endinterface

// File: rtl/scr1_lsu_outst_fifo.sv
// Outstanding-transaction tracker: circular FIFO of {cmd, addr, killed} entries.
// Latency: push/pop/kill take effect at the clock edge; head/count are registered.
// Backpressure: none internally; the caller never pushes when full without a pop.
// Ports: clk, rst_n (async active-low), push/push_entry, pop, kill_all, head, count.
module scr1_lsu_outst_fifo
    import scr1_lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  type_scr1_lsu_outst_s      push_entry,
    input  logic                      pop,
    input  logic                      kill_all,
    output type_scr1_lsu_outst_s      head,
    output logic [SCR1_LSU_CNT_W-1:0] count
);

    localparam int unsigned      PTR_W = scr1_lsu_ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    type_scr1_lsu_outst_s entries [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;

    // Explicit wrap keeps depth 1 correct where the pointer has a spare bit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= SCR1_LSU_OUTST_RESET;
            end
        end else begin
            // Marking free slots too is harmless: a push overwrites the whole entry.
            if (kill_all) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    entries[i].killed <= 1'b1;
                end
            end
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/scr1_pipe_lsu_mo.sv
// Multiple-outstanding load/store unit between EXU and DMEM, in-order completion.
// Latency: request forwarded to DMEM combinationally; completion reported in the response cycle.
// Backpressure: no DMEM request (no ack) while the tracker is full unless a response pops it.
// Ports: clk, rst_n (async active-low), lsu_if (scr1_pipe_lsu_mo_if.master).
// Option: SCR1_LSU_BYTE_LANE_EN enables store lane replication and address-based load lane select.
module scr1_pipe_lsu_mo
    import scr1_lsu_pkg::*;
#(
    parameter int unsigned SCR1_LSU_OUTST_DEPTH = 2
)(
    input  logic                      clk,
    input  logic                      rst_n,
    scr1_pipe_lsu_mo_if.master        lsu_if
);

    localparam logic [SCR1_LSU_CNT_W-1:0] DEPTH_CNT = SCR1_LSU_CNT_W'(SCR1_LSU_OUTST_DEPTH);

    type_scr1_lsu_cmd_sel_e      cmd;
    logic [1:0]                  addr_lo;
    logic                        cmd_store;
    logic                        misalign;
    logic                        resp_vld;
    logic                        pop;
    logic                        push;
    logic                        resp_report;
    logic                        misalign_exc;
    logic                        head_store;
    logic [SCR1_LSU_CNT_W-1:0]   count;
    type_scr1_lsu_outst_s        head;
    type_scr1_lsu_outst_s        push_entry;
    logic [SCR1_XLEN-1:0]        rdata_sh;
    logic [SCR1_XLEN-1:0]        ldata;

    assign cmd       = lsu_if.exu2lsu_cmd_i;
    assign addr_lo   = lsu_if.exu2lsu_addr_i[1:0];
    assign cmd_store = (cmd == SCR1_LSU_CMD_SB) || (cmd == SCR1_LSU_CMD_SH) || (cmd == SCR1_LSU_CMD_SW);

    always_comb begin
        misalign = 1'b0;
        case (cmd)
            SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, SCR1_LSU_CMD_SH: misalign = addr_lo[0];
            SCR1_LSU_CMD_LW, SCR1_LSU_CMD_SW:                   misalign = |addr_lo;
            default:                                            misalign = 1'b0;
        endcase
    end

    // Responses arriving with nothing outstanding (e.g. stale after reset) are ignored.
    assign resp_vld    = (lsu_if.dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_OK)
                      || (lsu_if.dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_ER);
    assign pop         = resp_vld && (count != '0);
    assign resp_report = pop && !head.killed;

    // A popping response frees a slot in the same cycle, so a full tracker can still accept.
    assign lsu_if.lsu2dmem_req_o    = lsu_if.exu2lsu_req_i && !misalign && !lsu_if.exu2lsu_flush_i
                                   && ((count < DEPTH_CNT) || pop);
    assign push                     = lsu_if.lsu2dmem_req_o && lsu_if.dmem2lsu_req_ack_i;
    assign lsu_if.lsu2exu_req_ack_o = push;

    // Misaligned accesses wait until older transactions drain so exceptions stay in order.
    assign misalign_exc = lsu_if.exu2lsu_req_i && misalign && (count == '0) && !resp_report;

    always_comb begin
        push_entry     = SCR1_LSU_OUTST_RESET;
        push_entry.cmd = cmd;
`ifdef SCR1_LSU_BYTE_LANE_EN
        push_entry.addr = addr_lo;
`endif
    end

    scr1_lsu_outst_fifo #(
        .DEPTH      (SCR1_LSU_OUTST_DEPTH)
    ) i_outst_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_all   (lsu_if.exu2lsu_flush_i),
        .head       (head),
        .count      (count)
    );

    // DMEM request channel
    assign lsu_if.lsu2dmem_cmd_o  = cmd_store ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    assign lsu_if.lsu2dmem_addr_o = lsu_if.exu2lsu_addr_i;

    always_comb begin
        case (cmd)
            SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU, SCR1_LSU_CMD_SB: lsu_if.lsu2dmem_width_o = SCR1_MEM_WIDTH_BYTE;
            SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, SCR1_LSU_CMD_SH: lsu_if.lsu2dmem_width_o = SCR1_MEM_WIDTH_HWORD;
            default:                                            lsu_if.lsu2dmem_width_o = SCR1_MEM_WIDTH_WORD;
        endcase
    end

    always_comb begin
        lsu_if.lsu2dmem_wdata_o = lsu_if.exu2lsu_sdata_i;
`ifdef SCR1_LSU_BYTE_LANE_EN
        case (cmd)
            SCR1_LSU_CMD_SB: lsu_if.lsu2dmem_wdata_o = {4{lsu_if.exu2lsu_sdata_i[7:0]}};
            SCR1_LSU_CMD_SH: lsu_if.lsu2dmem_wdata_o = {2{lsu_if.exu2lsu_sdata_i[15:0]}};
            default:         lsu_if.lsu2dmem_wdata_o = lsu_if.exu2lsu_sdata_i;
        endcase
`endif
    end

    // Load data extension from the head entry's command
`ifdef SCR1_LSU_BYTE_LANE_EN
    assign rdata_sh = lsu_if.dmem2lsu_rdata_i >> {head.addr, 3'b000};
`else
    assign rdata_sh = lsu_if.dmem2lsu_rdata_i;
`endif

    always_comb begin
        case (head.cmd)
            SCR1_LSU_CMD_LB:  ldata = {{24{rdata_sh[7]}},  rdata_sh[7:0]};
            SCR1_LSU_CMD_LBU: ldata = {24'd0,              rdata_sh[7:0]};
            SCR1_LSU_CMD_LH:  ldata = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            SCR1_LSU_CMD_LHU: ldata = {16'd0,              rdata_sh[15:0]};
            SCR1_LSU_CMD_LW:  ldata = rdata_sh;
            default:          ldata = '0;
        endcase
    end

    // EXU completion channel
    assign head_store = (head.cmd == SCR1_LSU_CMD_SB) || (head.cmd == SCR1_LSU_CMD_SH)
                     || (head.cmd == SCR1_LSU_CMD_SW);

    assign lsu_if.lsu2exu_rdy_o   = resp_report;
    assign lsu_if.lsu2exu_ldata_o = resp_report ? ldata : '0;
    assign lsu_if.lsu2exu_exc_o   = (resp_report && (lsu_if.dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_ER))
                                 || misalign_exc;
    assign lsu_if.lsu2exu_empty_o = (count == '0);

    always_comb begin
        lsu_if.lsu2exu_exc_code_o = SCR1_EXC_CODE_INSTR_MISALIGN;
        if (resp_report) begin
            lsu_if.lsu2exu_exc_code_o = head_store ? SCR1_EXC_CODE_ST_ACCESS_FAULT
                                                   : SCR1_EXC_CODE_LD_ACCESS_FAULT;
        end else if (misalign_exc) begin
            lsu_if.lsu2exu_exc_code_o = cmd_store ? SCR1_EXC_CODE_ST_ADDR_MISALIGN
                                                  : SCR1_EXC_CODE_LD_ADDR_MISALIGN;
        end
    end

endmodule
